fft_stage_sequencer: RTL and testbench

Sequences the pipelined fft_stages core through the log2(N) radix-2 passes of one FFT frame. Presents an ap_ctrl_chain block-level handshake upstream and drives an ap_ctrl_hs handshake on the stage core. Also drives the stage index and ping-pong buffer bank selects. Sits between the top-level FFT wrapper/dataflow region and the stage core.

---
 rtl/fft_stage_sequencer_if.sv | 51 +++++
 rtl/fft_stage_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Block-level and stage-core handshake bundle for fft_stage_sequencer.
// master = sequencer side, slave = wrapper/core side.
interface fft_stage_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_continue;
  logic [IDX_W-1:0] cfg_num_stages;
  logic             stg_start;
  logic             stg_ready;
  logic             stg_done;
  logic [IDX_W-1:0] stg_idx;
  logic             src_bank;
  logic             dst_bank;
  logic             out_bank;

  modport master (
    input  ap_start,
    input  ap_continue,
    input  cfg_num_stages,
    input  stg_ready,
    input  stg_done,
    output ap_ready,
    output ap_done,
    output ap_idle,
    output stg_start,
    output stg_idx,
    output src_bank,
    output dst_bank,
    output out_bank
  );

  modport slave (
    output ap_start,
    output ap_continue,
    output cfg_num_stages,
    output stg_ready,
    output stg_done,
    input  ap_ready,
    input  ap_done,
    input  ap_idle,
    input  stg_start,
    input  stg_idx,
    input  src_bank,
    input  dst_bank,
    input  out_bank
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Runs the log2(N) radix-2 passes of one FFT frame on the stage core.
// Optional FFT_SEQ_PERF_EN adds perf_cycles / perf_stall counters.
module fft_stage_sequencer #(
  parameter int LOG2N = 10,
  parameter int IDX_W = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  fft_stage_sequencer_if.master bus
`ifdef FFT_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } state_t;

  localparam logic [IDX_W-1:0] MAX_N = IDX_W'(LOG2N);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             src_q, src_d;
  logic             dst_q, dst_d;
  logic             out_q, out_d;
  logic             start_q, start_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             idle_q, idle_d;

  logic [IDX_W-1:0] n_cfg;
  logic             last;
  logic             advance;

  assign n_cfg = (bus.cfg_num_stages > MAX_N) ?
                 MAX_N : bus.cfg_num_stages;
  assign last  = (idx_q == n_q - ONE);

  // State and registered outputs; sync active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      src_q   <= 1'b0;
      dst_q   <= 1'b1;
      out_q   <= 1'b0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      out_q   <= out_d;
      start_q <= start_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    src_d   = src_q;
    out_d   = out_q;
    start_d = start_q;
    ready_d = 1'b0;
    done_d  = done_q;
    idle_d  = idle_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          n_d     = n_cfg;
          ready_d = 1'b1;
          idx_d   = '0;
          src_d   = 1'b0;
          idle_d  = 1'b0;
          if (n_cfg == '0) begin
            // done shows on the first FIN edge
            state_d = FIN;
            out_d   = 1'b0;
          end else begin
            state_d = ISSUE;
            start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (bus.stg_ready) begin
          start_d = 1'b0;
          state_d = WAIT;
          advance = bus.stg_done;
        end
      end
      WAIT: begin
        advance = bus.stg_done;
      end
      FIN: begin
        done_d = 1'b1;
        if (done_q && bus.ap_continue) begin
          state_d = IDLE;
          done_d  = 1'b0;
          idle_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (advance) begin
      if (last) begin
        state_d = FIN;
        done_d  = 1'b1;
        out_d   = ~src_q;
      end else begin
        state_d = ISSUE;
        idx_d   = idx_q + ONE;
        src_d   = ~src_q;
        start_d = 1'b1;
      end
    end
    dst_d = ~src_d;
  end

  assign bus.ap_ready  = ready_q;
  assign bus.ap_done   = done_q;
  assign bus.ap_idle   = idle_q;
  assign bus.stg_start = start_q;
  assign bus.stg_idx   = idx_q;
  assign bus.src_bank  = src_q;
  assign bus.dst_bank  = dst_q;
  assign bus.out_bank  = out_q;

`ifdef FFT_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] stall_q, stall_d;
  logic        busy;
  logic        stall;

  assign busy  = (state_q == ISSUE) || (state_q == WAIT);
  assign stall = start_q && !bus.stg_ready;

  // Perf counters; cleared with ap_ready, frozen outside busy states.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  // Saturating increment / clear for the perf counters.
  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    if (state_q == IDLE && bus.ap_start) begin
      cyc_d   = '0;
      stall_d = '0;
    end else begin
      if (busy && cyc_q != '1) begin
        cyc_d = cyc_q + 32'd1;
      end
      if (stall && stall_q != '1) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomized self-checking bench for fft_stage_sequencer.
// Core model drives handshakes on negedge; checks at negedge+1.
module tb_fft_stage_sequencer;
  localparam int LOG2N = 10;
  localparam int IDX_W = 4;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  fft_stage_sequencer_if #(.IDX_W(IDX_W)) bus ();

`ifdef FFT_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stall;
`endif

  fft_stage_sequencer #(
    .LOG2N(LOG2N),
    .IDX_W(IDX_W)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .bus        (bus.master)
`ifdef FFT_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stall (perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int rdly = 0;
  int ddly = 1;
  bit same = 1'b0;
  int rises = 0;
  int bad_inv = 0;
  int acc_idx[$];
  int acc_src[$];
  int acc_rise[$];
  logic prev_start = 1'b0;

  task automatic clr_mon();
    rises = 0;
    bad_inv = 0;
    acc_idx.delete();
    acc_src.delete();
    acc_rise.delete();
  endtask

  // stage core model and monitor
  initial begin
    int wcnt;
    int dcnt;
    int rise_idx;
    wcnt = 0;
    dcnt = 0;
    rise_idx = 0;
    bus.stg_ready = 1'b0;
    bus.stg_done = 1'b0;
    forever begin
      @(negedge ap_clk);
      bus.stg_done = 1'b0;
      if (ap_rst_n && bus.dst_bank !== ~bus.src_bank) bad_inv++;
      if (bus.stg_ready && prev_start) begin
        bus.stg_ready = 1'b0;
        wcnt = 0;
        if (!same) dcnt = ddly;
      end
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) bus.stg_done = 1'b1;
      end
      if (bus.stg_start && !prev_start) begin
        rises++;
        rise_idx = int'(bus.stg_idx);
      end
      if (bus.stg_start && !bus.stg_ready) begin
        if (wcnt < rdly) begin
          wcnt++;
        end else begin
          bus.stg_ready = 1'b1;
          if (same) bus.stg_done = 1'b1;
          acc_idx.push_back(int'(bus.stg_idx));
          acc_src.push_back(int'(bus.src_bank));
          acc_rise.push_back(rise_idx);
        end
      end
      prev_start = bus.stg_start;
    end
  end

  task automatic tick();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!bus.ap_done && cyc < 5000) begin
      tick();
      cyc++;
    end
    chk(tag, bus.ap_done, 1);
  endtask

  task automatic chk_stages(input int n);
    chk("starts", rises, n);
    chk("accepts", acc_idx.size(), n);
    for (int k = 0; k < acc_idx.size(); k++) begin
      chk("idx", acc_idx[k], k);
      chk("src", acc_src[k], k % 2);
      chk("idx_stable", acc_rise[k], k);
    end
    chk("out_bank", bus.out_bank, n % 2);
    chk("bank_inv", bad_inv, 0);
  endtask

  task automatic run_frame(input int cfg, input int rd, input int dd,
                           input bit sm, input int hold);
    int n;
    n = (cfg > LOG2N) ? LOG2N : cfg;
    rdly = rd;
    ddly = dd;
    same = sm;
    clr_mon();
    bus.cfg_num_stages = IDX_W'(cfg);
    bus.ap_start = 1'b1;
    tick();
    chk("ready", bus.ap_ready, 1);
    chk("idle_lo", bus.ap_idle, 0);
    bus.ap_start = 1'b0;
    bus.cfg_num_stages = IDX_W'($urandom_range(0, 15));
    if (n == 0) begin
      chk("n0_not_yet", bus.ap_done, 0);
      tick();
      chk("n0_done", bus.ap_done, 1);
    end else begin
      wait_done("done_seen");
    end
    chk_stages(n);
`ifdef FFT_SEQ_PERF_EN
    if (!sm) chk("perf_stall", perf_stall, n * rd);
`endif
    repeat (hold) tick();
    chk("done_held", bus.ap_done, 1);
    bus.ap_continue = 1'b1;
    tick();
    bus.ap_continue = 1'b0;
    chk("done_clr", bus.ap_done, 0);
    chk("idle_back", bus.ap_idle, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_idle"}, bus.ap_idle, 1);
    chk({tag, "_dst"}, bus.dst_bank, 1);
    chk({tag, "_src"}, bus.src_bank, 0);
    chk({tag, "_idx"}, bus.stg_idx, 0);
    chk({tag, "_start"}, bus.stg_start, 0);
    chk({tag, "_done"}, bus.ap_done, 0);
    chk({tag, "_ready"}, bus.ap_ready, 0);
    chk({tag, "_out"}, bus.out_bank, 0);
  endtask

  initial begin
    int cyc;
    int bad;
    bus.ap_start = 1'b0;
    bus.ap_continue = 1'b0;
    bus.cfg_num_stages = '0;
    repeat (3) tick();
    chk_reset_vals("rst");
    ap_rst_n = 1'b1;
    tick();

    run_frame(10, 0, 20, 1'b0, 5);
    run_frame(3, 0, 4, 1'b0, 2);
    run_frame(0, 0, 1, 1'b0, 1);
    run_frame(15, 0, 3, 1'b0, 1);
    run_frame(4, 7, 2, 1'b0, 1);
    run_frame(1, 0, 1, 1'b1, 1);

    // reset while waiting on stage 4
    rdly = 0;
    ddly = 20;
    same = 1'b0;
    clr_mon();
    bus.cfg_num_stages = IDX_W'(10);
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    cyc = 0;
    while (acc_idx.size() < 5 && cyc < 2000) begin
      tick();
      cyc++;
    end
    tick();
    chk("wait_idx4", bus.stg_idx, 4);
    chk("wait_start", bus.stg_start, 0);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    chk_reset_vals("mid");
    rises = 0;
    bad = 0;
    repeat (25) begin
      tick();
      if (bus.ap_done || !bus.ap_idle) bad++;
    end
    chk("late_done_ign", bad, 0);
    chk("late_no_start", rises, 0);
    run_frame(6, 1, 3, 1'b0, 0);

    // ap_start held across two frames with ap_continue held
    rdly = 0;
    ddly = 2;
    clr_mon();
    bus.cfg_num_stages = IDX_W'(2);
    bus.ap_start = 1'b1;
    bus.ap_continue = 1'b1;
    tick();
    chk("b2b_ready1", bus.ap_ready, 1);
    bus.cfg_num_stages = IDX_W'(3);
    wait_done("b2b_done1");
    chk_stages(2);
    clr_mon();
    tick();
    chk("b2b_gap", bus.ap_ready, 0);
    tick();
    chk("b2b_ready2", bus.ap_ready, 1);
    bus.ap_start = 1'b0;
    wait_done("b2b_done2");
    chk_stages(3);
    tick();
    chk("b2b_idle", bus.ap_idle, 1);
    bus.ap_continue = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_frame($urandom_range(0, 15), $urandom_range(0, 3),
                $urandom_range(1, 6), 1'b0, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
